// File: rtl/pe_drain.sv
// Output drain stage below the bottom PE row: saturates ACC_BW partial sums to
// the MUL_BW fixed-point format, buffers them in a FIFO and presents them on a
// valid/ready interface with tile-boundary tagging and error/saturation counters.
module pe_drain #(
  parameter int unsigned INT_BW = 5,
  parameter int unsigned FRA_BW = 10,
  parameter int unsigned MUL_BW = 16,
  parameter int unsigned ACC_BW = 32,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ROWS   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_valid,
  input  logic [ACC_BW-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [MUL_BW-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic [15:0]       sat_cnt,
  output logic              drop_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = (ROWS > 1) ? $clog2(ROWS) : 1;
  // Bit position of the output sign; everything above must be pure sign extension.
  localparam int unsigned SB = INT_BW + 2 * FRA_BW;
  localparam logic [CW:0]   DEPTH_L   = (CW + 1)'(DEPTH);
  localparam logic [TW-1:0] TCNT_LAST = TW'(ROWS - 1);
  localparam logic [MUL_BW-1:0] SAT_POS = {1'b0, {(MUL_BW - 1){1'b1}}};
  localparam logic [MUL_BW-1:0] SAT_NEG = {1'b1, {(MUL_BW - 1){1'b0}}};

  logic              sat_over, sat_under, sat_any;
  logic [MUL_BW-1:0] sat_word;
  logic              accept, push, pop;
  logic              unused_in_bits;

  logic              stage_v;
  logic              stage_sat;
  logic [MUL_BW-1:0] stage_data;
  logic [MUL_BW-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic [TW-1:0]     tcnt;

  // Low fraction bits are truncated away (round toward -inf).
  assign unused_in_bits = ^in_data[FRA_BW-1:0];

  // Range check: in range iff bits above SB all equal the sign bit.
  always_comb begin
    sat_over  = !in_data[ACC_BW-1] && (|in_data[ACC_BW-2:SB]);
    sat_under = in_data[ACC_BW-1] && !(&in_data[ACC_BW-2:SB]);
    sat_any   = sat_over || sat_under;
    if (sat_over) begin
      sat_word = SAT_POS;
    end else if (sat_under) begin
      sat_word = SAT_NEG;
    end else begin
      sat_word = in_data[FRA_BW+MUL_BW-1:FRA_BW];
    end
  end

  // Handshake decode; in_ready counts the in-flight stage word as occupied.
  always_comb begin
    in_ready  = (({1'b0, count}) + (CW + 1)'(stage_v)) < DEPTH_L;
    accept    = in_valid && in_ready;
    push      = stage_v;
    out_valid = (count != '0);
    pop       = out_valid && out_ready;
    out_data  = out_valid ? mem[rd_ptr] : '0;
    out_last  = out_valid && (tcnt == TCNT_LAST);
  end

  // FIFO storage; no reset needed since out_data is gated by out_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= stage_data;
    end
  end

  // Stage register, FIFO pointers, tile counter and status counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_v    <= 1'b0;
      stage_sat  <= 1'b0;
      stage_data <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      tcnt       <= '0;
      sat_cnt    <= '0;
      drop_err   <= 1'b0;
    end else if (clr) begin
      stage_v    <= 1'b0;
      stage_sat  <= 1'b0;
      stage_data <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      tcnt       <= '0;
      sat_cnt    <= '0;
      drop_err   <= 1'b0;
    end else begin
      stage_v <= accept;
      if (accept) begin
        stage_data <= sat_word;
        stage_sat  <= sat_any;
      end
      if (in_valid && !in_ready) begin
        drop_err <= 1'b1;
      end
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (stage_sat && (sat_cnt != 16'hFFFF)) begin
          sat_cnt <= sat_cnt + 16'd1;
        end
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        tcnt   <= (tcnt == TCNT_LAST) ? '0 : tcnt + 1'b1;
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_pe_drain.sv
// Directed bench for pe_drain (DEPTH=8, ROWS=4) with hand-computed expectations.
module tb_pe_drain;

  logic        clk = 1'b0;
  logic        rst, clr, in_valid, in_ready, out_valid, out_last, out_ready, drop_err;
  logic [31:0] in_data;
  logic [15:0] out_data, sat_cnt;

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [15:0] exp_q [$];
  int          tb_tcnt = 0;

  pe_drain #(
    .INT_BW(5), .FRA_BW(10), .MUL_BW(16), .ACC_BW(32), .DEPTH(8), .ROWS(4)
  ) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready), .sat_cnt(sat_cnt), .drop_err(drop_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check the current head against the model; called only when a pop will occur.
  task automatic pop_check();
    logic [15:0] e;
    chk("queue_nonempty", 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("out_data", 32'(out_data), 32'(e));
      chk("out_last", 32'(out_last), 32'(tb_tcnt == 3));
      tb_tcnt = (tb_tcnt + 1) % 4;
    end
  endtask

  // One cycle: drive inputs, record expected word if valid, check any pop.
  task automatic step(input logic v, input logic [31:0] d, input logic [15:0] e,
                      input logic rdy);
    in_valid  = v;
    in_data   = d;
    out_ready = rdy;
    if (v) begin
      chk("in_ready", 32'(in_ready), 32'd1);
      exp_q.push_back(e);
    end
    if (rdy && out_valid) pop_check();
    tick();
  endtask

  task automatic drain(input int max_cycles);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < max_cycles && exp_q.size() != 0; i++) begin
      if (out_valid) pop_check();
      tick();
    end
    chk("drained", 32'(exp_q.size()), 32'd0);
    chk("empty_after_drain", 32'(out_valid), 32'd0);
  endtask

  task automatic do_clr();
    clr      = 1'b1;
    in_valid = 1'b0;
    tick();
    clr = 1'b0;
    exp_q.delete();
    tb_tcnt = 0;
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_sat_cnt", 32'(sat_cnt), 32'd0);
    chk("rst_drop_err", 32'(drop_err), 32'd0);
    rst = 1'b0;
    tick();

    // Basic latency: one LSB word appears two edges after acceptance.
    in_valid = 1'b1; in_data = 32'h0000_0400;
    tick();
    in_valid = 1'b0;
    chk("lat_not_yet", 32'(out_valid), 32'd0);
    tick();
    chk("lat_valid", 32'(out_valid), 32'd1);
    chk("lat_data", 32'(out_data), 32'h0001);
    chk("lat_sat_cnt", 32'(sat_cnt), 32'd0);
    do_clr();
    chk("clr_empty", 32'(out_valid), 32'd0);

    // Saturation and exact boundaries.
    step(1'b1, 32'h0200_0000, 16'h7FFF, 1'b0);
    step(1'b1, 32'hFC00_0000, 16'h8000, 1'b0);
    step(1'b1, 32'h01FF_FFFF, 16'h7FFF, 1'b0);
    step(1'b1, 32'hFE00_0000, 16'h8000, 1'b0);
    step(1'b0, 32'h0, 16'h0, 1'b0);
    chk("sat_cnt_two", 32'(sat_cnt), 32'd2);
    drain(10);

    // Tile tagging: 8 streamed words, out_last on 4th and 8th.
    for (int k = 1; k <= 8; k++) step(1'b1, 32'(k) << 10, 16'(k), 1'b1);
    drain(10);

    // Overflow: 8 accepted with out_ready low, 9th dropped; clr-cycle input discarded.
    clr = 1'b1; in_valid = 1'b1; in_data = 32'h0000_0400;
    tick();
    clr = 1'b0; in_valid = 1'b0; exp_q.delete(); tb_tcnt = 0;
    chk("clr_no_drop", 32'(drop_err), 32'd0);
    for (int k = 1; k <= 8; k++) step(1'b1, 32'(k + 16) << 10, 16'(k + 16), 1'b0);
    in_valid = 1'b1; in_data = 32'h0000_7C00;
    chk("full_in_ready", 32'(in_ready), 32'd0);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("drop_err_set", 32'(drop_err), 32'd1);
    chk("drop_no_sat", 32'(sat_cnt), 32'd0);
    chk("hold_data", 32'(out_data), 32'h0011);
    drain(12);
    chk("drop_sticky", 32'(drop_err), 32'd1);

    // Pointer wrap: prefill 6, then 24 streamed with out_ready high.
    do_clr();
    for (int k = 0; k < 6; k++) step(1'b1, 32'(k + 32) << 10, 16'(k + 32), 1'b0);
    for (int k = 6; k < 30; k++) step(1'b1, 32'(k + 32) << 10, 16'(k + 32), 1'b1);
    drain(20);
    chk("wrap_no_drop", 32'(drop_err), 32'd0);

    // Asynchronous reset with 5 words queued.
    for (int k = 1; k <= 5; k++) step(1'b1, 32'(k) << 10, 16'(k), 1'b0);
    step(1'b0, 32'h0, 16'h0, 1'b0);
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_data", 32'(out_data), 32'd0);
    chk("async_rst_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    exp_q.delete(); tb_tcnt = 0;
    tick();

    // Clear with queued words, a saturated word, a drop, and tcnt mid-tile.
    step(1'b1, 32'h0200_0000, 16'h7FFF, 1'b0);
    step(1'b1, 32'h0000_0800, 16'h0002, 1'b0);
    step(1'b1, 32'h0000_0C00, 16'h0003, 1'b0);
    step(1'b0, 32'h0, 16'h0, 1'b1);
    for (int k = 4; k <= 9; k++) step(1'b1, 32'(k) << 10, 16'(k), 1'b0);
    in_valid = 1'b1; in_data = 32'h0000_0400;
    chk("clr_full_ready", 32'(in_ready), 32'd0);
    tick();
    chk("clr_pre_drop", 32'(drop_err), 32'd1);
    chk("clr_pre_sat", 32'(sat_cnt), 32'd1);
    clr = 1'b1; in_valid = 1'b1; in_data = 32'h0000_0400; out_ready = 1'b0;
    tick();
    clr = 1'b0; in_valid = 1'b0;
    exp_q.delete(); tb_tcnt = 0;
    chk("clr_valid", 32'(out_valid), 32'd0);
    chk("clr_sat_cnt", 32'(sat_cnt), 32'd0);
    chk("clr_drop_err", 32'(drop_err), 32'd0);
    chk("clr_in_ready", 32'(in_ready), 32'd1);
    tick();
    tick();
    chk("clr_input_discarded", 32'(out_valid), 32'd0);
    for (int k = 1; k <= 4; k++) step(1'b1, 32'(k + 8) << 10, 16'(k + 8), 1'b1);
    drain(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
